picorv32_pcpi_div_multi: RTL and testbench

//  Parametrised PCPI co-processor for RV M-extension DIV/DIVU/REM/REMU. Next generation of the PicoRV32

---
 rtl/picorv32_pcpi_div_multi.sv | 171 +++++++++++++++++
 tb/tb_picorv32_pcpi_div_multi.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/picorv32_pcpi_div_multi.sv
// PCPI divide/remainder co-processor for the RV M extension (DIV, DIVU, REM, REMU).
// Restoring division that resolves STEPS quotient bits per cycle.
// Zero divisor, signed overflow and |rs1| < |rs2| finish straight from LOAD.
//
//  state | meaning
//  ------+------------------------------------------------------------
//  IDLE  | waiting for a matching instruction on the PCPI bus
//  LOAD  | operands sampled, magnitudes taken, special cases resolved
//  RUN   | restoring division, cnt counts down the remaining cycles
//  DONE  | one-cycle ready/wr pulse carrying the result
module picorv32_pcpi_div_multi #(
    parameter int XLEN      = 32,
    parameter int STEPS     = 1,
    parameter int EARLY_OUT = 1
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            pcpi_valid,
    input  logic [31:0]     pcpi_insn,
    input  logic [XLEN-1:0] pcpi_rs1,
    input  logic [XLEN-1:0] pcpi_rs2,
    output logic            pcpi_wr,
    output logic [XLEN-1:0] pcpi_rd,
    output logic            pcpi_wait,
    output logic            pcpi_ready
);
    localparam int NCYC = XLEN / STEPS;
    localparam int CW   = $clog2(NCYC + 1);
    localparam int DW   = 2 * XLEN - 1;
    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t          state, state_nx;
    logic [1:0]      op_q;
    logic            neg_q, neg_r;
    logic [XLEN-1:0] dividend, quotient, mask;
    logic [DW-1:0]   divisor;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] rd_nx;

    logic            insn_match, op_signed, op_rem;
    logic [XLEN-1:0] abs1, abs2, spec_res, run_res;
    logic            rs2_zero, ovf, early, special;
    logic [XLEN-1:0] st_dividend, st_quot, st_mask;
    logic [DW-1:0]   st_divisor;
    logic            unused_insn_bits;

    assign insn_match = (pcpi_insn[6:0] == 7'b0110011) && (pcpi_insn[31:25] == 7'b0000001)
                        && pcpi_insn[14];
    assign unused_insn_bits = ^{pcpi_insn[24:15], pcpi_insn[11:7]};
    assign op_signed = ~op_q[0];
    assign op_rem    = op_q[1];

    // Operand magnitudes and the cases that need no iteration; |MIN| stays unsigned 2^(XLEN-1).
    always_comb begin
        abs1     = (op_signed && pcpi_rs1[XLEN-1]) ? -pcpi_rs1 : pcpi_rs1;
        abs2     = (op_signed && pcpi_rs2[XLEN-1]) ? -pcpi_rs2 : pcpi_rs2;
        rs2_zero = (pcpi_rs2 == '0);
        ovf      = op_signed && (pcpi_rs1 == MIN_VAL) && (pcpi_rs2 == '1);
        early    = (EARLY_OUT != 0) && (abs1 < abs2);
        special  = rs2_zero || ovf || early;
        if (rs2_zero)
            spec_res = op_rem ? pcpi_rs1 : '1;
        else if (ovf)
            spec_res = op_rem ? '0 : MIN_VAL;
        else
            spec_res = op_rem ? pcpi_rs1 : '0;
    end

    // STEPS chained restoring steps per RUN cycle, then the sign fix of the final result.
    always_comb begin
        st_dividend = dividend;
        st_divisor  = divisor;
        st_quot     = quotient;
        st_mask     = mask;
        for (int i = 0; i < STEPS; i++) begin
            if (st_divisor <= {{(XLEN-1){1'b0}}, st_dividend}) begin
                st_dividend = st_dividend - st_divisor[XLEN-1:0];
                st_quot     = st_quot | st_mask;
            end
            st_divisor = st_divisor >> 1;
            st_mask    = st_mask >> 1;
        end
        if (op_rem)
            run_res = neg_r ? -st_dividend : st_dividend;
        else
            run_res = neg_q ? -st_quot : st_quot;
    end

    // Next-state and next output value; a dropped pcpi_valid aborts LOAD and RUN.
    always_comb begin
        state_nx = state;
        rd_nx    = '0;
        case (state)
            IDLE: if (pcpi_valid && insn_match && !pcpi_ready) state_nx = LOAD;
            LOAD: begin
                if (!pcpi_valid) begin
                    state_nx = IDLE;
                end else if (special) begin
                    state_nx = DONE;
                    rd_nx    = spec_res;
                end else begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (!pcpi_valid) begin
                    state_nx = IDLE;
                end else if (cnt == CW'(1)) begin
                    state_nx = DONE;
                    rd_nx    = run_res;
                end
            end
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State register and registered bus outputs, all decoded from the next state.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= IDLE;
            pcpi_wait  <= 1'b0;
            pcpi_ready <= 1'b0;
            pcpi_wr    <= 1'b0;
            pcpi_rd    <= '0;
        end else begin
            state      <= state_nx;
            pcpi_wait  <= (state_nx == LOAD) || (state_nx == RUN);
            pcpi_ready <= (state_nx == DONE);
            pcpi_wr    <= (state_nx == DONE);
            pcpi_rd    <= rd_nx;
        end
    end

    // Division datapath: op latch at accept, operand setup in LOAD, iteration in RUN.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            op_q     <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            dividend <= '0;
            divisor  <= '0;
            quotient <= '0;
            mask     <= '0;
            cnt      <= '0;
        end else begin
            case (state)
                IDLE: if (pcpi_valid && insn_match && !pcpi_ready) op_q <= pcpi_insn[13:12];
                LOAD: begin
                    dividend <= abs1;
                    divisor  <= {abs2, {(XLEN-1){1'b0}}};
                    quotient <= '0;
                    mask     <= MIN_VAL;
                    cnt      <= CW'(NCYC);
                    neg_q    <= (op_q == 2'b00) && (pcpi_rs1[XLEN-1] != pcpi_rs2[XLEN-1]);
                    neg_r    <= (op_q == 2'b10) && pcpi_rs1[XLEN-1];
                end
                RUN: begin
                    dividend <= st_dividend;
                    divisor  <= st_divisor;
                    quotient <= st_quot;
                    mask     <= st_mask;
                    cnt      <= cnt - CW'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_picorv32_pcpi_div_multi.sv
// Self-checking bench for picorv32_pcpi_div_multi: directed vector table, abort/reset/ignore
// sequences and a random run against a native-arithmetic reference, through a result scoreboard.
module tb_picorv32_pcpi_div_multi;
    localparam int XLEN      = 32;
    localparam int STEPS     = 1;
    localparam int EARLY_OUT = 1;
    localparam int N         = XLEN / STEPS;
    localparam logic [XLEN-1:0] MINV = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [1:0] OP_DIV = 2'd0, OP_DIVU = 2'd1, OP_REM = 2'd2, OP_REMU = 2'd3;

    logic            clk = 1'b0;
    logic            resetn = 1'b0;
    logic            pcpi_valid = 1'b0;
    logic [31:0]     pcpi_insn = '0;
    logic [XLEN-1:0] pcpi_rs1 = '0;
    logic [XLEN-1:0] pcpi_rs2 = '0;
    logic            pcpi_wr;
    logic [XLEN-1:0] pcpi_rd;
    logic            pcpi_wait;
    logic            pcpi_ready;

    picorv32_pcpi_div_multi #(.XLEN(XLEN), .STEPS(STEPS), .EARLY_OUT(EARLY_OUT)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .pcpi_valid (pcpi_valid),
        .pcpi_insn  (pcpi_insn),
        .pcpi_rs1   (pcpi_rs1),
        .pcpi_rs2   (pcpi_rs2),
        .pcpi_wr    (pcpi_wr),
        .pcpi_rd    (pcpi_rd),
        .pcpi_wait  (pcpi_wait),
        .pcpi_ready (pcpi_ready)
    );

    always #5 clk = ~clk;

    // kind: 0 normal run, 1 zero-divisor/overflow, 2 early-out candidate
    typedef struct {
        logic [1:0]      op;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] exp;
        int              kind;
    } vec_t;

    vec_t            vecs[$];
    logic [XLEN-1:0] exp_q[$];
    int              lat_q[$];
    int              n_tests = 0;
    int              n_fail  = 0;

    function automatic logic [31:0] mk_insn(input logic [1:0] op);
        return {7'b0000001, 5'd2, 5'd1, 1'b1, op, 5'd3, 7'b0110011};
    endfunction

    function automatic int kind_lat(input int kind);
        if (kind == 1) return 2;
        if (kind == 2 && EARLY_OUT != 0) return 2;
        return 2 + N;
    endfunction

    function automatic logic [XLEN-1:0] model_rd(input logic [1:0] op, input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
        logic sgn, rem;
        sgn = ~op[0];
        rem = op[1];
        if (b == '0) return rem ? a : '1;
        if (sgn && a == MINV && b == '1) return rem ? '0 : MINV;
        if (sgn) return rem ? ($signed(a) % $signed(b)) : ($signed(a) / $signed(b));
        return rem ? (a % b) : (a / b);
    endfunction

    function automatic int model_lat(input logic [1:0] op, input logic [XLEN-1:0] a,
                                     input logic [XLEN-1:0] b);
        logic sgn;
        logic [XLEN-1:0] ma, mb;
        sgn = ~op[0];
        if (b == '0) return 2;
        if (sgn && a == MINV && b == '1) return 2;
        ma = (sgn && a[XLEN-1]) ? -a : a;
        mb = (sgn && b[XLEN-1]) ? -b : b;
        if (EARLY_OUT != 0 && ma < mb) return 2;
        return 2 + N;
    endfunction

    function automatic logic [XLEN-1:0] rnd_val(input int mode);
        logic [63:0] r;
        int s;
        r = {$urandom(), $urandom()};
        case (mode)
            0: return r[XLEN-1:0];
            1: begin
                s = int'($urandom_range(0, 40)) - 20;
                return XLEN'(s);
            end
            default: begin
                case ($urandom_range(0, 3))
                    0: return '0;
                    1: return '1;
                    2: return MINV;
                    default: return XLEN'(1);
                endcase
            end
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drives one instruction in the IDLE period after the previous result and follows it to ready.
    task automatic run_op(input string name, input logic [1:0] op, input logic [XLEN-1:0] a,
                          input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp, input int lat);
        logic            got, wait_ok;
        logic [XLEN-1:0] e;
        int              l;
        @(negedge clk);
        pcpi_insn  = mk_insn(op);
        pcpi_rs1   = a;
        pcpi_rs2   = b;
        pcpi_valid = 1'b1;
        exp_q.push_back(exp);
        lat_q.push_back(lat);
        got     = 1'b0;
        wait_ok = 1'b1;
        for (int k = 1; k <= N + 8 && !got; k++) begin
            @(negedge clk);
            if (pcpi_ready) begin
                got = 1'b1;
                if (!pcpi_wr || pcpi_wait) wait_ok = 1'b0;
                e = exp_q.pop_front();
                l = lat_q.pop_front();
                check({name, " rd"}, 64'(pcpi_rd), 64'(e));
                check({name, " latency"}, 64'(k), 64'(l));
                pcpi_valid = 1'b0;
            end else if (!pcpi_wait || pcpi_wr || pcpi_rd != '0) begin
                wait_ok = 1'b0;
            end
        end
        if (!got) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s timeout: no pcpi_ready within %0d cycles", name, N + 8);
            void'(exp_q.pop_front());
            void'(lat_q.pop_front());
            pcpi_valid = 1'b0;
        end
        check({name, " wait/wr window"}, 64'(wait_ok), 64'(1));
    endtask

    // Holds a non-matching instruction for 40 cycles; the divider must never respond.
    task automatic ignore_op(input string name, input logic [31:0] insn);
        logic quiet;
        @(negedge clk);
        pcpi_insn  = insn;
        pcpi_rs1   = XLEN'(100);
        pcpi_rs2   = XLEN'(7);
        pcpi_valid = 1'b1;
        quiet      = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (pcpi_wait || pcpi_ready || pcpi_wr || pcpi_rd != '0) quiet = 1'b0;
        end
        pcpi_valid = 1'b0;
        check({name, " no response"}, 64'(quiet), 64'(1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic            quiet, wait_seen;
        logic [1:0]      op;
        logic [XLEN-1:0] a, b;

        vecs.push_back('{OP_DIVU, XLEN'(100), XLEN'(7), XLEN'(14), 0});
        vecs.push_back('{OP_REMU, XLEN'(100), XLEN'(7), XLEN'(2), 0});
        vecs.push_back('{OP_DIV, XLEN'(-7), XLEN'(2), XLEN'(-3), 0});
        vecs.push_back('{OP_REM, XLEN'(-7), XLEN'(2), XLEN'(-1), 0});
        vecs.push_back('{OP_REM, XLEN'(7), XLEN'(-2), XLEN'(1), 0});
        vecs.push_back('{OP_DIV, XLEN'(-8), XLEN'(-2), XLEN'(4), 0});
        vecs.push_back('{OP_DIV, XLEN'(5), XLEN'(0), '1, 1});
        vecs.push_back('{OP_REMU, XLEN'(5), XLEN'(0), XLEN'(5), 1});
        vecs.push_back('{OP_DIV, MINV, '1, MINV, 1});
        vecs.push_back('{OP_REM, MINV, '1, '0, 1});
        vecs.push_back('{OP_DIVU, XLEN'(3), XLEN'(10), '0, 2});
        vecs.push_back('{OP_REMU, XLEN'(3), XLEN'(10), XLEN'(3), 2});
        vecs.push_back('{OP_DIV, XLEN'(-3), XLEN'(10), '0, 2});
        vecs.push_back('{OP_REM, XLEN'(-3), XLEN'(10), XLEN'(-3), 2});
        vecs.push_back('{OP_REMU, XLEN'(0), XLEN'(5), '0, 2});
        vecs.push_back('{OP_DIVU, '1, XLEN'(1), '1, 0});
        vecs.push_back('{OP_DIV, MINV, XLEN'(1), MINV, 0});
        vecs.push_back('{OP_DIV, XLEN'(7), XLEN'(7), XLEN'(1), 0});
        vecs.push_back('{OP_REMU, '1, XLEN'(16), XLEN'(15), 0});

        repeat (3) @(negedge clk);
        check("reset wait", 64'(pcpi_wait), 64'(0));
        check("reset ready", 64'(pcpi_ready), 64'(0));
        check("reset rd", 64'(pcpi_rd), 64'(0));
        resetn = 1'b1;

        foreach (vecs[i])
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp,
                   kind_lat(vecs[i].kind));

        // Abort: pcpi_valid dropped during period T+10.
        @(negedge clk);
        pcpi_insn  = mk_insn(OP_DIVU);
        pcpi_rs1   = XLEN'(100);
        pcpi_rs2   = XLEN'(7);
        pcpi_valid = 1'b1;
        wait_seen  = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (!pcpi_wait) wait_seen = 1'b0;
        end
        check("abort wait before drop", 64'(wait_seen), 64'(1));
        @(negedge clk);
        pcpi_valid = 1'b0;
        @(negedge clk);
        check("abort wait after drop", 64'(pcpi_wait), 64'(0));
        quiet = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (pcpi_ready || pcpi_wr || pcpi_wait) quiet = 1'b0;
        end
        check("abort no ready", 64'(quiet), 64'(1));

        // Synchronous reset in the middle of RUN.
        @(negedge clk);
        pcpi_insn  = mk_insn(OP_DIVU);
        pcpi_rs1   = XLEN'(100);
        pcpi_rs2   = XLEN'(7);
        pcpi_valid = 1'b1;
        repeat (5) @(negedge clk);
        resetn     = 1'b0;
        pcpi_valid = 1'b0;
        @(negedge clk);
        check("mid-run reset wait", 64'(pcpi_wait), 64'(0));
        check("mid-run reset ready", 64'(pcpi_ready | pcpi_wr), 64'(0));
        check("mid-run reset rd", 64'(pcpi_rd), 64'(0));
        resetn = 1'b1;
        run_op("post-reset DIVU 9/3", OP_DIVU, XLEN'(9), XLEN'(3), XLEN'(3), 2 + N);

        ignore_op("funct7=0", {7'b0000000, 5'd2, 5'd1, 3'b100, 5'd3, 7'b0110011});
        ignore_op("MUL", {7'b0000001, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011});
        ignore_op("wrong opcode", {7'b0000001, 5'd2, 5'd1, 3'b100, 5'd3, 7'b0010011});

        for (int i = 0; i < 1000; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = rnd_val(int'($urandom_range(0, 2)));
            b  = rnd_val(int'($urandom_range(0, 2)));
            run_op($sformatf("rand%0d op%0d %0h/%0h", i, op, a, b), op, a, b,
                   model_rd(op, a, b), model_lat(op, a, b));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
